// File: rtl/nr_pkg.sv
// Shared definitions for the Broyden solve controller and its datapath partners.
// Contents: the controller state enum, the default next_invJ latency, the default
// iteration-counter width, fp32 datapath dimensions, and a helper that sizes the
// latency timer.
package nr_pkg;

    localparam int unsigned FP_W         = 32;
    localparam int unsigned N_X          = 3;
    localparam int unsigned N_F          = 4;
    localparam int unsigned N_INVJ       = 12;
    localparam int unsigned INVJ_LAT_DEF = 6;
    localparam int unsigned ITER_W_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        EVAL   = 3'd2,
        UPDJ   = 3'd3,
        COMMIT = 3'd4,
        DONE   = 3'd5
    } nr_state_t;

    // Width of a down-counter that must hold INVJ_LAT-1.
    function automatic int unsigned latTimerW(input int unsigned lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/broyden_iter_ctrl_if.sv
// Control/handshake bundle between the Broyden controller and its surroundings.
// Signals: start, abort and max_iter from the host; step_req/step_ack with the step
// unit; feval_req/feval_ack/conv_in with the residual evaluator; commit to the state
// registers; busy, done, converged and iter_count as status back to the host.
// Modports: master = controller side, slave = host/datapath side.
interface broyden_iter_ctrl_if
    import nr_pkg::*;
#(
    parameter int unsigned ITER_W = ITER_W_DEF
);
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] max_iter;
    logic              step_req;
    logic              step_ack;
    logic              feval_req;
    logic              feval_ack;
    logic              conv_in;
    logic              commit;
    logic              busy;
    logic              done;
    logic              converged;
    logic [ITER_W-1:0] iter_count;

    modport master (
        input  start, abort, max_iter, step_ack, feval_ack, conv_in,
        output step_req, feval_req, commit, busy, done, converged, iter_count
    );

    modport slave (
        output start, abort, max_iter, step_ack, feval_ack, conv_in,
        input  step_req, feval_req, commit, busy, done, converged, iter_count
    );
endinterface

// File: rtl/nr_lat_timer.sv
// Loadable down-counter that times the fixed-latency next_invJ pipeline.
// Ports: clk, rst (sync, active-high), load (takes load_val), load_val, zero (count is 0).
// The counter stops at zero and stays there until the next load.
module nr_lat_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/broyden_iter_ctrl.sv
// Sequencing FSM for one Broyden quasi-Newton solve (fp32, 3 unknowns, 4 residuals).
// Each iteration: step unit -> residual evaluation -> fixed-latency next_invJ wait ->
// one-cycle commit. Ends on convergence, iteration limit, or abort. Control only.
// Ports: clk; rst (sync, active-high); ctrlBus (master side of broyden_iter_ctrl_if).
module broyden_iter_ctrl
    import nr_pkg::*;
#(
    parameter int unsigned INVJ_LAT = INVJ_LAT_DEF,
    parameter int unsigned ITER_W   = ITER_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    broyden_iter_ctrl_if.master        ctrlBus
);
    localparam int unsigned        TMR_W    = latTimerW(INVJ_LAT);
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(INVJ_LAT - 1);
    localparam logic [ITER_W-1:0]  ITER_MAX = '1;

    nr_state_t         state;
    logic [ITER_W-1:0] maxIterQ;
    logic              convFlag;
    logic              timerLoad;
    logic              timerZero;
    logic [ITER_W-1:0] iterNext;

    // Timer is armed on the non-converged evaluator ack; abort suppresses it.
    always_comb begin
        timerLoad = 1'b0;
        if (state == EVAL && ctrlBus.feval_ack && !ctrlBus.conv_in && !ctrlBus.abort) begin
            timerLoad = 1'b1;
        end
    end

    // Saturating increment of the commit count.
    always_comb begin
        iterNext = ctrlBus.iter_count;
        if (ctrlBus.iter_count != ITER_MAX) begin
            iterNext = ctrlBus.iter_count + ITER_W'(1);
        end
    end

    nr_lat_timer #(
        .W (TMR_W)
    ) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timerLoad),
        .load_val (TMR_LOAD),
        .zero     (timerZero)
    );

    // FSM with registered outputs; iter_count advances on the edge that enters COMMIT,
    // so the COMMIT cycle already sees the new count for the limit test.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            maxIterQ           <= '0;
            convFlag           <= 1'b0;
            ctrlBus.step_req   <= 1'b0;
            ctrlBus.feval_req  <= 1'b0;
            ctrlBus.commit     <= 1'b0;
            ctrlBus.busy       <= 1'b0;
            ctrlBus.done       <= 1'b0;
            ctrlBus.converged  <= 1'b0;
            ctrlBus.iter_count <= '0;
        end else begin
            ctrlBus.commit <= 1'b0;
            ctrlBus.done   <= 1'b0;

            if (ctrlBus.abort && state != IDLE) begin
                // Abort beats any ack seen this cycle; results keep their values.
                state             <= IDLE;
                ctrlBus.step_req  <= 1'b0;
                ctrlBus.feval_req <= 1'b0;
                ctrlBus.busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ctrlBus.start && !ctrlBus.abort) begin
                            maxIterQ           <= ctrlBus.max_iter;
                            convFlag           <= 1'b0;
                            ctrlBus.iter_count <= '0;
                            ctrlBus.converged  <= 1'b0;
                            if (ctrlBus.max_iter == '0) begin
                                state        <= DONE;
                                ctrlBus.done <= 1'b1;
                            end else begin
                                state            <= STEP;
                                ctrlBus.step_req <= 1'b1;
                                ctrlBus.busy     <= 1'b1;
                            end
                        end
                    end

                    STEP: begin
                        if (ctrlBus.step_ack) begin
                            state             <= EVAL;
                            ctrlBus.step_req  <= 1'b0;
                            ctrlBus.feval_req <= 1'b1;
                        end
                    end

                    EVAL: begin
                        if (ctrlBus.feval_ack) begin
                            ctrlBus.feval_req <= 1'b0;
                            if (ctrlBus.conv_in) begin
                                // Converged: skip the invJ wait, solve ends after this commit.
                                convFlag           <= 1'b1;
                                state              <= COMMIT;
                                ctrlBus.commit     <= 1'b1;
                                ctrlBus.iter_count <= iterNext;
                            end else begin
                                state <= UPDJ;
                            end
                        end
                    end

                    UPDJ: begin
                        if (timerZero) begin
                            state              <= COMMIT;
                            ctrlBus.commit     <= 1'b1;
                            ctrlBus.iter_count <= iterNext;
                        end
                    end

                    COMMIT: begin
                        if (convFlag) begin
                            state             <= DONE;
                            ctrlBus.done      <= 1'b1;
                            ctrlBus.busy      <= 1'b0;
                            ctrlBus.converged <= 1'b1;
                        end else if (ctrlBus.iter_count == maxIterQ) begin
                            state        <= DONE;
                            ctrlBus.done <= 1'b1;
                            ctrlBus.busy <= 1'b0;
                        end else begin
                            state            <= STEP;
                            ctrlBus.step_req <= 1'b1;
                        end
                    end

                    DONE: begin
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
